iso_bus_rx_array: RTL and testbench
===================================

Name: iso_bus_rx_array

Overview:
- Parametrised, multi-channel successor to the single-bit registered bus receiver in the M1/M3 isolation test case.
- Captures NCH channels of W-bit data from a switchable power domain into the always-on domain.
- Provides isolation sequencing: ACTIVE, ISOLATED and SETTLE states.
- Clamps or holds outputs during isolation, according to mode.
- Counts input activity that arrives while capture is blocked.

Parameters:
- NCH, 4, number of channels.
- W, 8, data width per channel.
- SETTLE_CYC, 4, cycles to wait after isolate deasserts before capture resumes. 0 means no settle period.
- CLAMP_MODE, 0. 0: drive CLAMP_VAL on all channels while isolated. 1: hold the last captured value.
- CLAMP_VAL, 0, W-bit clamp value.

Ports:
- ck  input  1  clock.
- arst_n  input  1  reset. Asynchronous, active-low.
- isolate  input  1  isolation request from power control, synchronous to ck.
- data_ready  input  NCH  per-channel valid strobe from the switchable domain.
- data_in  input  NCH*W  per-channel data. Channel i occupies bits [i*W +: W].
- data_tx  output  NCH*W  registered captured data.
- tx_valid  output  NCH  one-cycle pulse per channel when data_tx[i] was updated by a capture.
- iso_state  output  2  FSM state: 0 ACTIVE, 1 ISOLATED, 2 SETTLE.
- drop_cnt  output  16  saturating count of blocked-activity cycles.

Behaviour:
- One clock domain only. All state updates on posedge ck. Reset is asynchronous on negedge arst_n.
- Reset values:
  - data_tx = 0 on all channels.
  - tx_valid = 0.
  - iso_state = ACTIVE.
  - drop_cnt = 0.
  - Internal settle counter = 0.
  - Reset mid-operation aborts any state immediately, including an in-progress SETTLE.
- capture_en = (state == ACTIVE) && !isolate. This is combinational, so isolate blocks capture in the same cycle it is first sampled high.
- Capture, per channel i, when capture_en && data_ready[i]:
  - data_tx[i] <= data_in[i].
  - tx_valid[i] <= 1.
  - Latency is 1 cycle from data_ready to tx_valid / data_tx.
- Otherwise tx_valid[i] <= 0.
- Channels are fully independent. Any subset may capture in the same cycle.
- FSM transitions:
  - ACTIVE, isolate=1 -> ISOLATED. In the same edge, if CLAMP_MODE=0, data_tx <= CLAMP_VAL on all channels. If CLAMP_MODE=1, data_tx is held.
  - ISOLATED, isolate=1 -> stay. data_tx stays at its clamp or held value. tx_valid = 0.
  - ISOLATED, isolate=0 -> if SETTLE_CYC=0, go to ACTIVE. Otherwise go to SETTLE and load counter = SETTLE_CYC-1.
  - SETTLE, isolate=1 -> ISOLATED and counter cleared. The clamp is not re-applied, because data_tx already holds the clamp or held value.
  - SETTLE, isolate=0, counter != 0 -> decrement the counter.
  - SETTLE, isolate=0, counter == 0 -> ACTIVE.
  - Net effect: SETTLE lasts exactly SETTLE_CYC cycles. Capture resumes on the first ACTIVE cycle with isolate=0.
- In SETTLE, data_tx keeps its ISOLATED value and tx_valid = 0.
- drop_cnt:
  - Increments by 1 in each cycle where capture_en=0 and |data_ready=1. It counts cycles, not channels.
  - Saturates at 16'hFFFF and does not wrap.
  - Cleared only by reset.
- Inputs data_ready/data_in may be X while isolate=1 or the state is not ACTIVE. They must not propagate to any output or to drop_cnt. In those states, treat data_ready as 0 for the drop count only if it is X.

Test Plan:
- Reset and pass-through: release arst_n, state ACTIVE. Drive data_ready=4'b0101, ch0=8'hA5, ch2=8'h3C for 1 cycle -> next cycle tx_valid=4'b0101, data_tx ch0=A5, ch2=3C, ch1/ch3=00. One cycle later tx_valid=0 and data remain.
- Clamp mode (CLAMP_MODE=0, CLAMP_VAL=8'hEE): after a capture, raise isolate with data_ready=4'hF in the same cycle -> no capture. Next edge data_tx=EE on all channels, iso_state=1, drop_cnt=1. Hold isolate 5 cycles with data_ready=4'hF -> drop_cnt=6, tx_valid stays 0.
- Hold mode (CLAMP_MODE=1): ch1=8'h77 captured, then isolate -> data_tx ch1 stays 77 throughout ISOLATED and SETTLE.
- Settle timing (SETTLE_CYC=4): drop isolate -> iso_state=2 for exactly 4 cycles, then 0. data_ready asserted in the last SETTLE cycle is dropped. data_ready asserted in the first ACTIVE cycle is captured one cycle later.
- Re-isolate and edge cases:
  - Reassert isolate in the 2nd SETTLE cycle -> ISOLATED. On the next release, a full 4 SETTLE cycles occur.
  - With SETTLE_CYC=0, release goes straight to ACTIVE.
  - Assert arst_n=0 mid-SETTLE -> all outputs at reset values asynchronously.
- Saturation: force 70000 blocked cycles with data_ready=1 -> drop_cnt=16'hFFFF and remains there.

Source files
------------

// File: rtl/iso_bus_rx_array.sv
// Multi-channel receiver that moves data from a switchable power domain into the always-on domain.
// Isolation sequencing: ACTIVE -> ISOLATED -> SETTLE -> ACTIVE, with clamp/hold and a count of blocked activity.
module iso_bus_rx_array #(
  parameter int             NCH        = 4,
  parameter int             W          = 8,
  parameter int             SETTLE_CYC = 4,
  parameter int             CLAMP_MODE = 0,
  parameter logic [W-1:0]   CLAMP_VAL  = '0
) (
  input  logic             ck,
  input  logic             arst_n,
  input  logic             isolate,
  input  logic [NCH-1:0]   data_ready,
  input  logic [NCH*W-1:0] data_in,
  output logic [NCH*W-1:0] data_tx,
  output logic [NCH-1:0]   tx_valid,
  output logic [1:0]       iso_state,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    ISOLATED = 2'd1,
    SETTLE   = 2'd2
  } state_t;

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          clamp_now;
  logic          capture_en;

  // data_ready is a one-cycle strobe with no backpressure: a capture happens
  // on the edge where capture_en && data_ready[i], otherwise the beat is lost.
  assign capture_en = (state == ACTIVE) && !isolate;
  assign iso_state  = state;

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      state <= ACTIVE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clamp_now = 1'b0;
    case (state)
      ACTIVE: begin
        if (isolate) begin
          state_nxt = ISOLATED;
          clamp_now = (CLAMP_MODE == 0);
        end
      end
      ISOLATED: begin
        if (!isolate) begin
          if (SETTLE_CYC == 0) begin
            state_nxt = ACTIVE;
          end else begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end
        end
      end
      SETTLE: begin
        // data_tx already carries the clamp/held value, so re-entry does not clamp again
        if (isolate) begin
          state_nxt = ISOLATED;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = ACTIVE;
        end
      end
      default: begin
        state_nxt = ACTIVE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      data_tx  <= '0;
      tx_valid <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (capture_en && data_ready[i]) begin
          data_tx[i*W +: W] <= data_in[i*W +: W];
          tx_valid[i]       <= 1'b1;
        end else begin
          tx_valid[i] <= 1'b0;
          if (clamp_now) begin
            data_tx[i*W +: W] <= CLAMP_VAL;
          end
        end
      end
    end
  end

  // Counts cycles (not channels) with activity that could not be captured.
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      drop_cnt <= '0;
    end else if (!capture_en && (|data_ready) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_iso_bus_rx_array.sv
// Bench for iso_bus_rx_array: three configurations (clamp, hold, no-settle) driven from shared
// inputs and compared every cycle against a cycle-level behavioural model.
module tb_iso_bus_rx_array;

  logic        ck = 1'b0;
  logic        arst_n = 1'b0;
  logic        isolate = 1'b0;
  logic [3:0]  data_ready = '0;
  logic [31:0] data_in = '0;

  logic [31:0] dtx [3];
  logic [3:0]  txv [3];
  logic [1:0]  st  [3];
  logic [15:0] dc  [3];

  int n_total = 0;
  int n_bad   = 0;

  // clock / reset
  always #5 ck = ~ck;

  iso_bus_rx_array #(.NCH(4), .W(8), .SETTLE_CYC(4), .CLAMP_MODE(0), .CLAMP_VAL(8'hEE)) dut_a (
    .ck(ck), .arst_n(arst_n), .isolate(isolate), .data_ready(data_ready), .data_in(data_in),
    .data_tx(dtx[0]), .tx_valid(txv[0]), .iso_state(st[0]), .drop_cnt(dc[0]));

  iso_bus_rx_array #(.NCH(4), .W(8), .SETTLE_CYC(4), .CLAMP_MODE(1), .CLAMP_VAL(8'h55)) dut_b (
    .ck(ck), .arst_n(arst_n), .isolate(isolate), .data_ready(data_ready), .data_in(data_in),
    .data_tx(dtx[1]), .tx_valid(txv[1]), .iso_state(st[1]), .drop_cnt(dc[1]));

  iso_bus_rx_array #(.NCH(4), .W(8), .SETTLE_CYC(0), .CLAMP_MODE(0), .CLAMP_VAL(8'h11)) dut_c (
    .ck(ck), .arst_n(arst_n), .isolate(isolate), .data_ready(data_ready), .data_in(data_in),
    .data_tx(dtx[2]), .tx_valid(txv[2]), .iso_state(st[2]), .drop_cnt(dc[2]));

  // reference model: per-instance configuration and abstract state
  int         m_cm     [3] = '{0, 1, 0};
  logic [7:0] m_cv     [3] = '{8'hEE, 8'h55, 8'h11};
  int         m_settle [3] = '{4, 4, 0};
  bit         m_iso    [3];
  int         m_left   [3];   // settle cycles still to spend
  logic [7:0] m_data   [3][4];
  logic [3:0] m_valid  [3];
  int         m_drop   [3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_iso[k]   = 1'b0;
      m_left[k]  = 0;
      m_valid[k] = '0;
      m_drop[k]  = 0;
      for (int c = 0; c < 4; c++) m_data[k][c] = '0;
    end
  endfunction

  function automatic void model_step(bit iso_in, logic [3:0] rdy, logic [31:0] din);
    for (int k = 0; k < 3; k++) begin
      bit act;
      bit cap;
      act = !m_iso[k] && (m_left[k] == 0);
      cap = act && !iso_in;
      m_valid[k] = '0;
      if (cap) begin
        for (int c = 0; c < 4; c++) begin
          if (rdy[c]) begin
            m_data[k][c]  = din[c*8 +: 8];
            m_valid[k][c] = 1'b1;
          end
        end
      end else if (rdy != 4'd0 && m_drop[k] < 65535) begin
        m_drop[k]++;
      end
      if (act) begin
        if (iso_in) begin
          m_iso[k] = 1'b1;
          if (m_cm[k] == 0) for (int c = 0; c < 4; c++) m_data[k][c] = m_cv[k];
        end
      end else if (m_iso[k]) begin
        if (!iso_in) begin
          m_iso[k]  = 1'b0;
          m_left[k] = m_settle[k];
        end
      end else begin
        if (iso_in) begin
          m_iso[k]  = 1'b1;
          m_left[k] = 0;
        end else begin
          m_left[k]--;
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_tx(int k);
    logic [31:0] r;
    for (int c = 0; c < 4; c++) r[c*8 +: 8] = m_data[k][c];
    return r;
  endfunction

  function automatic logic [31:0] exp_st(int k);
    if (m_iso[k]) return 32'd1;
    if (m_left[k] > 0) return 32'd2;
    return 32'd0;
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("tx%0d", k),    dtx[k],          exp_tx(k));
      check($sformatf("vld%0d", k),   32'(txv[k]),     32'(m_valid[k]));
      check($sformatf("state%0d", k), 32'(st[k]),      exp_st(k));
      check($sformatf("drop%0d", k),  32'(dc[k]),      32'(m_drop[k]));
    end
  endtask

  // driver
  task automatic cycle(input bit iso_in, input logic [3:0] rdy, input logic [31:0] din);
    @(negedge ck);
    isolate    = iso_in;
    data_ready = rdy;
    data_in    = din;
    @(posedge ck);
    model_step(iso_in, rdy, din);
    #1;
    check_all();
  endtask

  initial begin
    bit iso_r;
    logic [31:0] d;

    model_reset();
    #12;
    check_all();
    @(negedge ck);
    arst_n = 1'b1;

    // pass-through
    cycle(1'b0, 4'b0101, 32'hDE3C_BEA5);
    check("pt_tx", dtx[0], 32'h003C_00A5);
    check("pt_vld", 32'(txv[0]), 32'h5);
    cycle(1'b0, 4'b0000, $urandom);
    check("pt_vld_off", 32'(txv[0]), 32'h0);
    check("pt_hold", dtx[0], 32'h003C_00A5);

    // clamp vs hold
    cycle(1'b0, 4'b0010, 32'h0000_7700);
    cycle(1'b1, 4'hF, $urandom);
    check("clamp_tx", dtx[0], 32'hEEEE_EEEE);
    check("clamp_st", 32'(st[0]), 32'd1);
    check("clamp_drop1", 32'(dc[0]), 32'd1);
    check("hold_tx", dtx[1], 32'h003C_77A5);
    repeat (5) cycle(1'b1, 4'hF, $urandom);
    check("clamp_drop6", 32'(dc[0]), 32'd6);
    check("iso_vld", 32'(txv[0]), 32'd0);

    // settle timing: 4 cycles of SETTLE, last-cycle strobe dropped, first ACTIVE strobe captured
    cycle(1'b0, 4'h0, $urandom);
    check("settle_st0", 32'(st[0]), 32'd2);
    check("nosettle_st", 32'(st[2]), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, 4'h0, $urandom);
      check("settle_st", 32'(st[0]), 32'd2);
      check("settle_hold", dtx[1], 32'h003C_77A5);
    end
    cycle(1'b0, 4'hF, $urandom);
    check("settle_end_st", 32'(st[0]), 32'd0);
    check("settle_drop", 32'(dc[0]), 32'd7);
    check("settle_last_vld", 32'(txv[0]), 32'd0);
    d = $urandom;
    cycle(1'b0, 4'hF, d);
    check("resume_vld", 32'(txv[0]), 32'hF);
    check("resume_tx", dtx[0], d);

    // re-isolate during the 2nd SETTLE cycle, then a full settle on release
    cycle(1'b1, 4'h0, $urandom);
    cycle(1'b0, 4'h0, $urandom);
    cycle(1'b0, 4'h0, $urandom);
    cycle(1'b1, 4'h0, $urandom);
    check("reiso_st", 32'(st[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'h0, $urandom);
      check("resettle_st", 32'(st[0]), 32'd2);
    end
    cycle(1'b0, 4'h0, $urandom);
    check("resettle_done", 32'(st[0]), 32'd0);

    // asynchronous reset in the middle of SETTLE
    cycle(1'b1, 4'h0, $urandom);
    cycle(1'b0, 4'h0, $urandom);
    cycle(1'b0, 4'h0, $urandom);
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    check("arst_st", 32'(st[0]), 32'd0);
    check("arst_tx", dtx[1], 32'd0);
    check_all();
    @(negedge ck);
    isolate    = 1'b0;
    data_ready = '0;
    arst_n     = 1'b1;

    // randomized traffic with sticky isolation requests
    iso_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) iso_r = !iso_r;
      cycle(iso_r, 4'($urandom_range(0, 15)), $urandom);
    end

    // drop counter saturation
    for (int i = 0; i < 70000; i++) cycle(1'b1, 4'($urandom_range(1, 15)), $urandom);
    for (int k = 0; k < 3; k++) check($sformatf("sat%0d", k), 32'(dc[k]), 32'h0000_FFFF);
    repeat (3) cycle(1'b1, 4'hF, $urandom);
    check("sat_stay", 32'(dc[0]), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
